// File: rtl/b01_obs_pkg.sv
// Shared definitions for the b01 observation trace buffer: FSM encoding,
// trace-entry field layout and the occupancy width helper.
package b01_obs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    DONE    = 2'b10
  } obs_state_e;

  localparam int OUTP_BIT  = 0;
  localparam int OVF_BIT   = 1;
  localparam int STAMP_LSB = 2;

  // Occupancy must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/obs_trace_buffer_fifo.sv
// Synchronous FIFO for trace entries: registered storage, no fall-through,
// full+pop accepts the push, flush empties it on the next edge.
module obs_fifo
  import b01_obs_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10,
  parameter int LVL_W = level_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == {LVL_W{1'b0}});
  assign full      = (count_r == LVL_W'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign level     = count_r;
  assign head      = mem_r[rd_ptr_r];

  // Storage array; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (!flush && do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + LVL_W'(1);
        2'b01:   count_r <= count_r - LVL_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/obs_trace_buffer.sv
// Capture stage for the b01 comparator: windowed, timestamped sampling of
// outp/overflw into a FIFO drained by a valid/ready consumer.
module obs_trace_buffer
  import b01_obs_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STAMP_W     = 8,
  parameter int MAX_SAMPLES = 32,
  parameter int LOST_W      = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          clear,
  input  logic                          obs,
  input  logic                          outp,
  input  logic                          overflw,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [STAMP_W+1:0]            rd_data,
  output logic [level_width(DEPTH)-1:0] level,
  output logic [1:0]                    state,
  output logic                          lost,
  output logic [LOST_W-1:0]             lost_cnt,
  output logic                          done
);

  localparam int LVL_W   = level_width(DEPTH);
  localparam int ENTRY_W = STAMP_W + 2;
  localparam int CNT_W   = $clog2(MAX_SAMPLES + 1);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_CAPTURE = CAPTURE;
  localparam logic [1:0] ST_DONE    = DONE;

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic               done_r;
  logic [STAMP_W-1:0] stamp_r;
  logic [CNT_W-1:0]   sample_cnt_r;
  logic               lost_r;
  logic [LOST_W-1:0]  lost_cnt_r;
  logic               capture_s;
  logic               event_s;
  logic               last_sample_s;
  logic               enter_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic               full_s;
  logic               empty_s;
  logic [ENTRY_W-1:0] entry_s;

  assign capture_s     = (state_r == ST_CAPTURE);
  assign event_s       = capture_s && obs;
  assign last_sample_s = (sample_cnt_r == CNT_W'(MAX_SAMPLES - 1));
  assign enter_s       = !clear && start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign pop_s         = rd_valid && rd_ready;
  // A full FIFO still takes the sample when the consumer frees a slot this cycle.
  assign push_s        = event_s && !clear && (!full_s || pop_s);
  assign drop_s        = event_s && !clear && full_s && !pop_s;

  // Assemble the trace entry from the live DUT outputs and current stamp.
  always_comb begin
    entry_s                             = {ENTRY_W{1'b0}};
    entry_s[OUTP_BIT]                   = outp;
    entry_s[OVF_BIT]                    = overflw;
    entry_s[STAMP_LSB +: STAMP_W]       = stamp_r;
  end

  // Window FSM: clear wins, then stop (only in CAPTURE), then start.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_nxt_s = ST_CAPTURE;
          else       state_nxt_s = ST_IDLE;
        end
        ST_CAPTURE: begin
          if (stop || (event_s && last_sample_s)) state_nxt_s = ST_DONE;
          else                                    state_nxt_s = ST_CAPTURE;
        end
        ST_DONE: begin
          if (start) state_nxt_s = ST_CAPTURE;
          else       state_nxt_s = ST_DONE;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State and done flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Stamp and per-window sample counters; both restart on window entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stamp_r      <= {STAMP_W{1'b0}};
      sample_cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      stamp_r      <= {STAMP_W{1'b0}};
      sample_cnt_r <= {CNT_W{1'b0}};
    end else if (enter_s) begin
      stamp_r      <= {STAMP_W{1'b0}};
      sample_cnt_r <= {CNT_W{1'b0}};
    end else if (capture_s) begin
      stamp_r <= stamp_r + STAMP_W'(1);
      if (event_s) begin
        sample_cnt_r <= sample_cnt_r + CNT_W'(1);
      end
    end
  end

  // Drop accounting: sticky flag plus saturating count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lost_r     <= 1'b0;
      lost_cnt_r <= {LOST_W{1'b0}};
    end else if (clear) begin
      lost_r     <= 1'b0;
      lost_cnt_r <= {LOST_W{1'b0}};
    end else if (drop_s) begin
      lost_r <= 1'b1;
      if (lost_cnt_r != {LOST_W{1'b1}}) begin
        lost_cnt_r <= lost_cnt_r + LOST_W'(1);
      end
    end
  end

  obs_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (clear),
    .push  (push_s),
    .pop   (pop_s),
    .din   (entry_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level),
    .head  (rd_data)
  );

  assign rd_valid = !empty_s;
  assign state    = state_r;
  assign lost     = lost_r;
  assign lost_cnt = lost_cnt_r;
  assign done     = done_r;

endmodule

// File: tb/tb_obs_trace_buffer.sv
// Directed bench for obs_trace_buffer; a second instance with a 4-bit stamp
// shares the stimulus to exercise timestamp wrap.
module tb_obs_trace_buffer;

  logic       clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic       clear;
  logic       obs;
  logic       outp;
  logic       overflw;
  logic       rd_ready;
  logic       rd_valid;
  logic [9:0] rd_data;
  logic [4:0] level;
  logic [1:0] state;
  logic       lost;
  logic [3:0] lost_cnt;
  logic       done;
  logic       rd_valid_w;
  logic [5:0] rd_data_w;
  logic [4:0] level_w;
  logic [1:0] state_w;
  logic       lost_w;
  logic [3:0] lost_cnt_w;
  logic       done_w;

  int n_checks = 0;
  int n_fail   = 0;

  obs_trace_buffer #(.DEPTH(16), .STAMP_W(8), .MAX_SAMPLES(32), .LOST_W(4)) u_dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .obs(obs), .outp(outp), .overflw(overflw), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .level(level), .state(state),
    .lost(lost), .lost_cnt(lost_cnt), .done(done)
  );

  obs_trace_buffer #(.DEPTH(16), .STAMP_W(4), .MAX_SAMPLES(32), .LOST_W(4)) u_dut_w (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .obs(obs), .outp(outp), .overflw(overflw), .rd_valid(rd_valid_w),
    .rd_ready(rd_ready), .rd_data(rd_data_w), .level(level_w), .state(state_w),
    .lost(lost_w), .lost_cnt(lost_cnt_w), .done(done_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    obs = 1'b0; outp = 1'b0; overflw = 1'b0; rd_ready = 1'b0;
    #2;
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_data", 32'(rd_data), 32'd0);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_lost", 32'(lost), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Basic capture: CAPTURE cycle 0 follows the start edge.
    start = 1'b1; tick(); start = 1'b0;
    check_eq("basic_state", 32'(state), 32'd1);
    tick(); tick();
    obs = 1'b1; outp = 1'b1; overflw = 1'b0; tick();
    obs = 1'b0; outp = 1'b0;
    check_eq("basic_lvl1", 32'(level), 32'd1);
    check_eq("basic_valid", 32'(rd_valid), 32'd1);
    tick(); tick();
    obs = 1'b1; outp = 1'b0; overflw = 1'b1; tick();
    obs = 1'b0; overflw = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("basic_done_st", 32'(state), 32'd2);
    check_eq("basic_done", 32'(done), 32'd1);
    check_eq("basic_e0", 32'(rd_data), 32'd9);
    tick();
    check_eq("basic_hold", 32'(rd_data), 32'd9);
    check_eq("basic_lvl2", 32'(level), 32'd2);
    rd_ready = 1'b1; tick();
    check_eq("basic_e1", 32'(rd_data), 32'd22);
    tick(); rd_ready = 1'b0;
    check_eq("basic_lvl0", 32'(level), 32'd0);
    check_eq("basic_empty", 32'(rd_valid), 32'd0);
    check_eq("basic_still_done", 32'(state), 32'd2);

    // Auto-close from DONE, draining as we go; head in cycle c is stamp c-1.
    start = 1'b1; tick(); start = 1'b0;
    check_eq("ac_restart", 32'(state), 32'd1);
    obs = 1'b1; rd_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c == 18) begin
        check_eq("ac_stamp17", 32'(rd_data[9:2]), 32'd17);
        check_eq("wrap_stamp1", 32'(rd_data_w[5:2]), 32'd1);
      end
      if (c == 31) check_eq("ac_st_c31", 32'(state), 32'd1);
      tick();
    end
    check_eq("ac_state", 32'(state), 32'd2);
    check_eq("ac_done", 32'(done), 32'd1);
    check_eq("ac_last", 32'(rd_data[9:2]), 32'd31);
    tick(); tick(); tick();
    check_eq("ac_nopush", 32'(level), 32'd0);
    check_eq("ac_nopush_w", 32'(level_w), 32'd0);
    obs = 1'b0; rd_ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    check_eq("clr_idle", 32'(state), 32'd0);
    check_eq("clr_done", 32'(done), 32'd0);

    // Overflow: 20 events into 16 slots with no consumer.
    start = 1'b1; tick(); start = 1'b0;
    obs = 1'b1;
    repeat (20) tick();
    obs = 1'b0;
    check_eq("ovf_level", 32'(level), 32'd16);
    check_eq("ovf_lost", 32'(lost), 32'd1);
    check_eq("ovf_lost_cnt", 32'(lost_cnt), 32'd4);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("ovf_stamp%0d", i), 32'(rd_data[9:2]), 32'(i));
      tick();
    end
    rd_ready = 1'b0;
    check_eq("ovf_drained", 32'(level), 32'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    check_eq("ovf_clr_lost", 32'(lost), 32'd0);
    check_eq("ovf_clr_cnt", 32'(lost_cnt), 32'd0);

    // Full with simultaneous pop: new entry {16,1,1} lands at the tail.
    start = 1'b1; tick(); start = 1'b0;
    obs = 1'b1;
    repeat (16) tick();
    check_eq("fp_full", 32'(level), 32'd16);
    outp = 1'b1; overflw = 1'b1; rd_ready = 1'b1; tick();
    obs = 1'b0; outp = 1'b0; overflw = 1'b0; rd_ready = 1'b0;
    check_eq("fp_level", 32'(level), 32'd16);
    check_eq("fp_lost", 32'(lost), 32'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 0)  check_eq("fp_head", 32'(rd_data), 32'd4);
      if (i == 15) check_eq("fp_tail", 32'(rd_data), 32'd67);
      tick();
    end
    rd_ready = 1'b0;
    check_eq("fp_drained", 32'(level), 32'd0);

    // Clear mid-capture with 5 queued entries and a pop/push pending.
    obs = 1'b1;
    repeat (5) tick();
    check_eq("clr_lvl5", 32'(level), 32'd5);
    clear = 1'b1; rd_ready = 1'b1; tick();
    clear = 1'b0; rd_ready = 1'b0; obs = 1'b0;
    check_eq("clr_level", 32'(level), 32'd0);
    check_eq("clr_valid", 32'(rd_valid), 32'd0);
    check_eq("clr_lost", 32'(lost), 32'd0);
    check_eq("clr_state", 32'(state), 32'd0);
    tick();
    check_eq("clr_level2", 32'(level), 32'd0);

    // Async reset between edges from a full, lossy DONE state.
    start = 1'b1; tick(); start = 1'b0;
    obs = 1'b1;
    repeat (20) tick();
    obs = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("ar_pre_done", 32'(done), 32'd1);
    check_eq("ar_pre_lost", 32'(lost), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check_eq("ar_level", 32'(level), 32'd0);
    check_eq("ar_valid", 32'(rd_valid), 32'd0);
    check_eq("ar_data", 32'(rd_data), 32'd0);
    check_eq("ar_state", 32'(state), 32'd0);
    check_eq("ar_lost", 32'(lost), 32'd0);
    check_eq("ar_lost_cnt", 32'(lost_cnt), 32'd0);
    check_eq("ar_done", 32'(done), 32'd0);
    check_eq("ar_level_w", 32'(level_w), 32'd0);
    #20;
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
